traffic_light_controller: RTL and testbench
===========================================

# traffic_light_controller

Two-road intersection sequencer built on the team's 3-bit one-hot lamp encoding: RED=3'b100, GREEN=3'b010, YELLOW=3'b001, bit order [0:2]. It drives a north-south lamp group and an east-west lamp group through timed green, yellow and all-red clearance phases. Pedestrian requests are latched and served in a dedicated all-red WALK phase. It replaces free-running single-lamp cycling at intersection level and sits directly in front of the lamp drivers.

## Interface
- GREEN_CYCLES, 8: cycles each green phase is held (≥1)
- YELLOW_CYCLES, 3: cycles each yellow phase is held (≥1)
- ALLRED_CYCLES, 2: cycles each all-red clearance is held (≥1)
- WALK_CYCLES, 6: cycles the pedestrian WALK phase is held (≥1)
- CNT_W, 4: phase counter width; must satisfy 2^CNT_W ≥ max duration
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = timers advance; 0 = freeze current phase
- ped_req  in  1  pedestrian button, level or pulse, sampled each clk
- light_ns  out  [0:2]  north-south lamp, one-hot RED/GREEN/YELLOW
- light_ew  out  [0:2]  east-west lamp, one-hot RED/GREEN/YELLOW
- walk  out  1  pedestrian WALK indicator
- ped_pend  out  1  latched pedestrian request awaiting service

## Operation
- States: NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B, WALK.
- Sequence: NS_GREEN → NS_YELLOW → ALLRED_A → EW_GREEN → EW_YELLOW → ALLRED_B.
- ALLRED_B exits to WALK if ped_pend=1, otherwise to NS_GREEN.
- WALK exits to NS_GREEN.
- Output decode (Moore, from state register only):
  - NS_GREEN: ns=GREEN, ew=RED.
  - NS_YELLOW: ns=YELLOW, ew=RED.
  - EW_GREEN: ns=RED, ew=GREEN.
  - EW_YELLOW: ns=RED, ew=YELLOW.
  - ALLRED_A, ALLRED_B, WALK: both RED.
  - walk=1 only in WALK.
- Lamp outputs are always exactly one-hot. Both groups are never non-RED simultaneously.
- Phase counter: cleared to 0 on every state entry; increments when enable=1. State advances on the edge where enable=1 and count==DUR-1, where DUR is the current phase's parameter.
- enable=0: state and counter hold; outputs unchanged; ped_req is still latched.
- ped_pend: set on any cycle with ped_req=1 while state≠WALK; cleared on the edge entering WALK. Clear dominates a simultaneous set. ped_req during WALK is ignored.
- The ALLRED_B exit decision uses registered ped_pend only. A request first seen in the final ALLRED_B cycle is served on the next round.

## Timing
- Reset (rst_n=0, async): state=ALLRED_B, count=0, ped_pend=0. Outputs: light_ns=3'b100, light_ew=3'b100, walk=0.
- After rst_n deasserts with enable=1: both RED for ALLRED_CYCLES cycles, then NS_GREEN.
- Phase duration is exactly DUR enabled cycles. Output change is visible in the same cycle as the state change; there is no extra latency.
- Full round without pedestrian: 2·GREEN + 2·YELLOW + 2·ALLRED cycles = 26 with defaults. With WALK: +WALK_CYCLES = 32.
- Reset mid-phase: immediate return to reset values; any pending request is discarded.

## Structure
- Shared package traffic_pkg:
  - lamp constants RED/GREEN/YELLOW (3 bits, [0:2]);
  - state encoding (3 bits) for the 7 states.
- One sub-module, phase_timer: CNT_W counter with clear, enable, duration input and done output (count==dur-1 && enable).
- Top level holds the FSM, ped_pend latch and output decode.

## Test plan
- Reset: hold rst_n=0 mid-operation → ns=100, ew=100, walk=0, ped_pend=0 asynchronously. Release with enable=1 → NS_GREEN (ns=010) after 2 cycles.
- Free run, ped_req=0, enable=1, defaults: ns=010 ×8, 001 ×3, 100 ×2 while ew=010 ×8, 001 ×3. Then all-red ×2; period 26; one-hot checked every cycle.
- One-cycle ped_req pulse during EW_GREEN: ped_pend=1 next cycle; WALK (walk=1, both RED) for 6 cycles after ALLRED_B; ped_pend=0 on WALK entry; then NS_GREEN.
- ped_req held high across WALK: not re-latched during WALK. ped_req in the last ALLRED_B cycle with ped_pend=0 goes to NS_GREEN, and WALK occurs the following round.
- enable=0 for 5 cycles in NS_YELLOW after 1 elapsed cycle: ns=001 held the whole time. After re-enable, exactly 2 more yellow cycles, then ALLRED_A.
- Parameters GREEN=1, YELLOW=1, ALLRED=1, WALK=1, CNT_W=1: each phase lasts exactly 1 cycle; round = 6 cycles (7 with ped).

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Lamp encodings, FSM state encoding and lamp decode helpers for
//            the two-road intersection sequencer.
// Revision : 1.0
// ============================================================================
package traffic_pkg;

  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    WALK      = 3'd6
  } state_t;

  function automatic logic [0:2] lamp_ns(input state_t s);
    case (s)
      NS_GREEN:  lamp_ns = GREEN;
      NS_YELLOW: lamp_ns = YELLOW;
      default:   lamp_ns = RED;
    endcase
  endfunction

  function automatic logic [0:2] lamp_ew(input state_t s);
    case (s)
      EW_GREEN:  lamp_ew = GREEN;
      EW_YELLOW: lamp_ew = YELLOW;
      default:   lamp_ew = RED;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Brief    : Phase counter; done pulses on the enabled cycle where the count
//            reaches the last cycle of the current phase.
// Revision : 1.0
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign done = enable && (r_count == last);

endmodule
`default_nettype wire

// File: rtl/traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_controller
// Brief    : Two-road intersection sequencer with latched pedestrian requests
//            served in an all-red WALK phase.
// Revision : 1.0
// ============================================================================
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 6,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ped_req,
  output logic [0:2] light_ns,
  output logic [0:2] light_ew,
  output logic       walk,
  output logic       ped_pend
);

  // Last count value of each phase; keeps a duration of 2^CNT_W representable.
  localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_walk_last   = CNT_W'(WALK_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] w_last;
  logic             w_done;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_done),
    .enable (enable),
    .last   (w_last),
    .done   (w_done)
  );

  always_comb begin
    w_last = c_allred_last;
    case (r_state)
      NS_GREEN, EW_GREEN:   w_last = c_green_last;
      NS_YELLOW, EW_YELLOW: w_last = c_yellow_last;
      WALK:                 w_last = c_walk_last;
      default:              w_last = c_allred_last;
    endcase
  end

  always_comb begin
    w_next = r_state;
    if (w_done) begin
      case (r_state)
        NS_GREEN:  w_next = NS_YELLOW;
        NS_YELLOW: w_next = ALLRED_A;
        ALLRED_A:  w_next = EW_GREEN;
        EW_GREEN:  w_next = EW_YELLOW;
        EW_YELLOW: w_next = ALLRED_B;
        ALLRED_B:  w_next = ped_pend ? WALK : NS_GREEN;
        default:   w_next = NS_GREEN;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ALLRED_B;
      light_ns <= RED;
      light_ew <= RED;
      walk     <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      r_state  <= w_next;
      light_ns <= lamp_ns(w_next);
      light_ew <= lamp_ew(w_next);
      walk     <= (w_next == WALK);
      if (w_next == WALK && r_state != WALK) begin
        ped_pend <= 1'b0;
      end else if (ped_req && r_state != WALK) begin
        ped_pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_controller
// Brief    : Directed bench for the default and minimum-duration controllers.
// Revision : 1.0
// ============================================================================
module tb_traffic_light_controller;

  localparam logic [0:2] R = 3'b100;
  localparam logic [0:2] G = 3'b010;
  localparam logic [0:2] Y = 3'b001;

  logic clk = 1'b0;
  logic rst_n, enable, ped_req;
  logic rst2_n, enable2, ped_req2;
  logic [0:2] light_ns, light_ew, light_ns2, light_ew2;
  logic walk, ped_pend, walk2, ped_pend2;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  traffic_light_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .ped_req  (ped_req),
    .light_ns (light_ns),
    .light_ew (light_ew),
    .walk     (walk),
    .ped_pend (ped_pend)
  );

  traffic_light_controller #(
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .ALLRED_CYCLES (1),
    .WALK_CYCLES   (1),
    .CNT_W         (1)
  ) dut_min (
    .clk      (clk),
    .rst_n    (rst2_n),
    .enable   (enable2),
    .ped_req  (ped_req2),
    .light_ns (light_ns2),
    .light_ew (light_ew2),
    .walk     (walk2),
    .ped_pend (ped_pend2)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check n consecutive cycles of one phase, sampling at the falling edge.
  task automatic phase(input int sel, input logic [0:2] ns, input logic [0:2] ew,
                       input logic wk, input logic pd, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic [0:2] ons, oew;
      logic       ow, op;
      if (sel == 0) begin
        ons = light_ns;  oew = light_ew;  ow = walk;  op = ped_pend;
      end else begin
        ons = light_ns2; oew = light_ew2; ow = walk2; op = ped_pend2;
      end
      check($sformatf("%s[%0d].ns", tag, i), {1'b0, ons}, {1'b0, ns});
      check($sformatf("%s[%0d].ew", tag, i), {1'b0, oew}, {1'b0, ew});
      check($sformatf("%s[%0d].walk", tag, i), {3'b0, ow}, {3'b0, wk});
      check($sformatf("%s[%0d].pend", tag, i), {3'b0, op}, {3'b0, pd});
      check($sformatf("%s[%0d].safe", tag, i),
            {3'b0, ($onehot(ons) && $onehot(oew) && (ons == R || oew == R))}, 4'd1);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; ped_req = 1'b0;
    rst2_n = 1'b0; enable2 = 1'b1; ped_req2 = 1'b0;
    repeat (2) @(negedge clk);
    phase(0, R, R, 0, 0, 1, "reset");
    phase(1, R, R, 0, 0, 1, "reset_min");

    // Round 1: free run, no pedestrian
    rst_n = 1'b1;
    phase(0, R, R, 0, 0, 2, "startup");
    phase(0, G, R, 0, 0, 8, "r1_nsg");
    phase(0, Y, R, 0, 0, 3, "r1_nsy");
    phase(0, R, R, 0, 0, 2, "r1_ara");
    phase(0, R, G, 0, 0, 8, "r1_ewg");
    phase(0, R, Y, 0, 0, 3, "r1_ewy");
    phase(0, R, R, 0, 0, 2, "r1_arb");

    // Round 2: one-cycle pulse in EW_GREEN
    phase(0, G, R, 0, 0, 8, "r2_nsg");
    phase(0, Y, R, 0, 0, 3, "r2_nsy");
    phase(0, R, R, 0, 0, 2, "r2_ara");
    phase(0, R, G, 0, 0, 1, "r2_ewg");
    ped_req = 1'b1;
    phase(0, R, G, 0, 0, 1, "r2_ewg_req");
    ped_req = 1'b0;
    phase(0, R, G, 0, 1, 6, "r2_ewg_pend");
    phase(0, R, Y, 0, 1, 3, "r2_ewy");
    phase(0, R, R, 0, 1, 2, "r2_arb");
    phase(0, R, R, 1, 0, 6, "r2_walk");

    // Round 3: request held through WALK
    ped_req = 1'b1;
    phase(0, G, R, 0, 0, 1, "r3_nsg");
    phase(0, G, R, 0, 1, 7, "r3_nsg_pend");
    phase(0, Y, R, 0, 1, 3, "r3_nsy");
    phase(0, R, R, 0, 1, 2, "r3_ara");
    phase(0, R, G, 0, 1, 8, "r3_ewg");
    phase(0, R, Y, 0, 1, 3, "r3_ewy");
    phase(0, R, R, 0, 1, 2, "r3_arb");
    phase(0, R, R, 1, 0, 6, "r3_walk_held");
    ped_req = 1'b0;

    // Round 4: request only in the final ALLRED_B cycle
    phase(0, G, R, 0, 0, 8, "r4_nsg");
    phase(0, Y, R, 0, 0, 3, "r4_nsy");
    phase(0, R, R, 0, 0, 2, "r4_ara");
    phase(0, R, G, 0, 0, 8, "r4_ewg");
    phase(0, R, Y, 0, 0, 3, "r4_ewy");
    phase(0, R, R, 0, 0, 1, "r4_arb");
    ped_req = 1'b1;
    phase(0, R, R, 0, 0, 1, "r4_arb_last");
    ped_req = 1'b0;

    // Round 5: deferred request served
    phase(0, G, R, 0, 1, 8, "r5_nsg");
    phase(0, Y, R, 0, 1, 3, "r5_nsy");
    phase(0, R, R, 0, 1, 2, "r5_ara");
    phase(0, R, G, 0, 1, 8, "r5_ewg");
    phase(0, R, Y, 0, 1, 3, "r5_ewy");
    phase(0, R, R, 0, 1, 2, "r5_arb");
    phase(0, R, R, 1, 0, 6, "r5_walk");

    // Round 6: freeze in NS_YELLOW, request latched while frozen
    phase(0, G, R, 0, 0, 8, "r6_nsg");
    phase(0, Y, R, 0, 0, 1, "r6_nsy");
    enable = 1'b0;
    ped_req = 1'b1;
    phase(0, Y, R, 0, 0, 1, "r6_frz_req");
    ped_req = 1'b0;
    phase(0, Y, R, 0, 1, 4, "r6_frz");
    enable = 1'b1;
    phase(0, Y, R, 0, 1, 2, "r6_nsy_rest");
    phase(0, R, R, 0, 1, 2, "r6_ara");
    phase(0, R, G, 0, 1, 8, "r6_ewg");
    phase(0, R, Y, 0, 1, 3, "r6_ewy");
    phase(0, R, R, 0, 1, 2, "r6_arb");
    phase(0, R, R, 1, 0, 6, "r6_walk");

    // Asynchronous reset mid-phase discards the pending request
    ped_req = 1'b1;
    phase(0, G, R, 0, 0, 1, "r7_nsg");
    ped_req = 1'b0;
    phase(0, G, R, 0, 1, 2, "r7_nsg_pend");
    #3 rst_n = 1'b0;
    #1;
    check("async_rst.ns", {1'b0, light_ns}, {1'b0, R});
    check("async_rst.ew", {1'b0, light_ew}, {1'b0, R});
    check("async_rst.walk", {3'b0, walk}, 4'd0);
    check("async_rst.pend", {3'b0, ped_pend}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    phase(0, R, R, 0, 0, 2, "rerelease");
    phase(0, G, R, 0, 0, 8, "r8_nsg");

    // Minimum-duration instance: 6-cycle round, 7 with WALK
    rst2_n = 1'b1;
    phase(1, R, R, 0, 0, 1, "m_start");
    phase(1, G, R, 0, 0, 1, "m_nsg");
    phase(1, Y, R, 0, 0, 1, "m_nsy");
    phase(1, R, R, 0, 0, 1, "m_ara");
    phase(1, R, G, 0, 0, 1, "m_ewg");
    phase(1, R, Y, 0, 0, 1, "m_ewy");
    phase(1, R, R, 0, 0, 1, "m_arb");
    ped_req2 = 1'b1;
    phase(1, G, R, 0, 0, 1, "m2_nsg");
    ped_req2 = 1'b0;
    phase(1, Y, R, 0, 1, 1, "m2_nsy");
    phase(1, R, R, 0, 1, 1, "m2_ara");
    phase(1, R, G, 0, 1, 1, "m2_ewg");
    phase(1, R, Y, 0, 1, 1, "m2_ewy");
    phase(1, R, R, 0, 1, 1, "m2_arb");
    phase(1, R, R, 1, 0, 1, "m2_walk");
    phase(1, G, R, 0, 0, 1, "m3_nsg");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
